// File: rtl/mux_canales_reg_pkg.sv
// Shared constants and sizing helpers for the registered channel multiplexer.
package mux_canales_reg_pkg;

  localparam logic MODO_SEL = 1'b0;
  localparam logic MODO_RR  = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Channel index width never drops below one bit.
  function automatic int sel_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/mux_canales_reg_arbitro_rr.sv
// Round-robin channel finder: first valid channel at or after the pointer, wrapping.
module arbitro_rr
  import mux_canales_reg_pkg::*;
#(
  parameter int  N_ENTRADAS = 4,
  localparam int SEL_W      = sel_width(N_ENTRADAS)
) (
  input  logic [N_ENTRADAS-1:0] valid_i,
  input  logic [SEL_W-1:0]      ptr_i,
  output logic [SEL_W-1:0]      grant_o,
  output logic                  grant_ok_o
);

  logic [SEL_W-1:0] idx;

  // Scan in priority order starting at the pointer; the first hit locks the grant.
  always_comb begin
    grant_o    = '0;
    grant_ok_o = 1'b0;
    idx        = '0;
    for (int i = 0; i < N_ENTRADAS; i++) begin
      idx = SEL_W'((int'(ptr_i) + i) % N_ENTRADAS);
      if (!grant_ok_o && valid_i[idx]) begin
        grant_ok_o = 1'b1;
        grant_o    = idx;
      end
    end
  end

endmodule

// File: rtl/mux_canales_reg.sv
// N-input registered multiplexer with valid/ready handshake, selecting by explicit
// index or round-robin, feeding one output register that stalls on back-pressure.
module mux_canales_reg
  import mux_canales_reg_pkg::*;
#(
  parameter int  ANCHO      = 11,
  parameter int  N_ENTRADAS = 4,
  localparam int SEL_W      = sel_width(N_ENTRADAS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        modo,
  input  logic [SEL_W-1:0]            sel,
  input  logic [N_ENTRADAS*ANCHO-1:0] entrada,
  input  logic [N_ENTRADAS-1:0]       entrada_valida,
  output logic [N_ENTRADAS-1:0]       entrada_lista,
  output logic [ANCHO-1:0]            salida,
  output logic                        salida_valida,
  output logic [SEL_W-1:0]            salida_canal,
  input  logic                        salida_lista
);

  logic                   carga;
  logic                   transfer;
  logic                   elegido_ok;
  logic [SEL_W-1:0]       elegido;
  logic [SEL_W-1:0]       rr_grant;
  logic                   rr_ok;
  logic [ANCHO-1:0]       datos_elegido;
  logic [SEL_W-1:0]       ptr_q, ptr_d;
  logic [ANCHO-1:0]       datos_q;
  logic                   valida_q;
  logic [SEL_W-1:0]       canal_q;

  arbitro_rr #(
    .N_ENTRADAS(N_ENTRADAS)
  ) u_arbitro (
    .valid_i   (entrada_valida),
    .ptr_i     (ptr_q),
    .grant_o   (rr_grant),
    .grant_ok_o(rr_ok)
  );

  // The output register can accept a word when empty or being drained this cycle.
  assign carga = !valida_q || salida_lista;

  always_comb begin
    if (modo == MODO_RR) begin
      elegido    = rr_grant;
      elegido_ok = rr_ok;
    end else begin
      elegido    = sel;
      elegido_ok = (int'(sel) < N_ENTRADAS);
    end
  end

  always_comb begin
    entrada_lista = '0;
    datos_elegido = '0;
    for (int c = 0; c < N_ENTRADAS; c++) begin
      entrada_lista[c] = !reset && carga && elegido_ok && (elegido == SEL_W'(c));
      if (elegido == SEL_W'(c)) datos_elegido = entrada[c*ANCHO +: ANCHO];
    end
  end

  assign transfer = |(entrada_valida & entrada_lista);

  // Pointer advances past the served channel only in round-robin mode.
  always_comb begin
    ptr_d = ptr_q;
    if (transfer && (modo == MODO_RR)) begin
      ptr_d = (int'(elegido) == N_ENTRADAS - 1) ? '0 : elegido + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      datos_q  <= '0;
      valida_q <= 1'b0;
      canal_q  <= '0;
      ptr_q    <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (carga) begin
        valida_q <= transfer;
        if (transfer) begin
          datos_q <= datos_elegido;
          canal_q <= elegido;
        end
      end
    end
  end

  assign salida        = datos_q;
  assign salida_valida = valida_q;
  assign salida_canal  = canal_q;

endmodule
